// File: rtl/part_wb.sv
// Writeback stage of the five-stage MIPS pipeline.
// Holds the MEM/WB register, extracts and extends sub-word load data,
// selects the register-file write data and counts retired instructions.
module part_wb #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             StallW,
  input  logic             FlushW,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [2:0]       LoadTypeM,
  input  logic [31:0]      ALUOutM,
  input  logic [31:0]      ReadDataM,
  input  logic [4:0]       WriteRegM,
  output logic             RegWriteW,
  output logic [4:0]       WriteRegW,
  output logic [31:0]      ResultW,
  output logic             ValidW,
  output logic [CNT_W-1:0] RetireCnt
);

  typedef enum logic [2:0] {
    LD_W   = 3'd0,
    LD_B   = 3'd1,
    LD_BU  = 3'd2,
    LD_H   = 3'd3,
    LD_HU  = 3'd4
  } load_type_e;

  logic             valid_q,     valid_d;
  logic             regwrite_q,  regwrite_d;
  logic             memtoreg_q,  memtoreg_d;
  logic [2:0]       ldtype_q,    ldtype_d;
  logic [31:0]      aluout_q,    aluout_d;
  logic [31:0]      rdata_q,     rdata_d;
  logic [4:0]       wreg_q,      wreg_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_val;

  // Next-state of the MEM/WB register: flush beats stall, stall holds everything.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    ldtype_d   = ldtype_q;
    aluout_d   = aluout_q;
    rdata_d    = rdata_q;
    wreg_d     = wreg_q;
    cnt_d      = cnt_q;
    if (FlushW || !StallW) begin
      // Data fields load on a flush too; only the control bits are forced to a bubble.
      memtoreg_d = MemtoRegM;
      ldtype_d   = LoadTypeM;
      aluout_d   = ALUOutM;
      rdata_d    = ReadDataM;
      wreg_d     = WriteRegM;
      if (FlushW) begin
        valid_d    = 1'b0;
        regwrite_d = 1'b0;
      end else begin
        valid_d    = ValidM;
        regwrite_d = RegWriteM;
        if (ValidM) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // MEM/WB register and retire counter with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      ldtype_q   <= '0;
      aluout_q   <= '0;
      rdata_q    <= '0;
      wreg_q     <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      ldtype_q   <= ldtype_d;
      aluout_q   <= aluout_d;
      rdata_q    <= rdata_d;
      wreg_q     <= wreg_d;
      cnt_q      <= cnt_d;
    end
  end

  // Little-endian lane selection; halfword ignores address bit 0.
  always_comb begin
    byte_sel = rdata_q[7:0];
    case (aluout_q[1:0])
      2'd0: byte_sel = rdata_q[7:0];
      2'd1: byte_sel = rdata_q[15:8];
      2'd2: byte_sel = rdata_q[23:16];
      2'd3: byte_sel = rdata_q[31:24];
      default: byte_sel = rdata_q[7:0];
    endcase
    half_sel = aluout_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  // Sign/zero extension by load type; unknown encodings behave as LW.
  always_comb begin
    load_val = rdata_q;
    case (load_type_e'(ldtype_q))
      LD_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   load_val = {24'd0, byte_sel};
      LD_H:    load_val = {{16{half_sel[15]}}, half_sel};
      LD_HU:   load_val = {16'd0, half_sel};
      default: load_val = rdata_q;
    endcase
  end

  assign WriteRegW = wreg_q;
  assign ValidW    = valid_q;
  assign RegWriteW = regwrite_q & valid_q & (wreg_q != 5'd0);
  assign ResultW   = memtoreg_q ? load_val : aluout_q;
  assign RetireCnt = cnt_q;

endmodule

// File: tb/tb_part_wb.sv
// Directed self-checking bench for the writeback stage.
module tb_part_wb;

  logic        CLK = 1'b0;
  logic        reset, StallW, FlushW, ValidM, RegWriteM, MemtoRegM;
  logic [2:0]  LoadTypeM;
  logic [31:0] ALUOutM, ReadDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteW, ValidW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic [31:0] RetireCnt;
  logic        RegWriteW4, ValidW4;
  logic [4:0]  WriteRegW4;
  logic [31:0] ResultW4;
  logic [3:0]  RetireCnt4;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  part_wb #(.CNT_W(32)) dut (
    .CLK(CLK), .reset(reset), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .LoadTypeM(LoadTypeM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .WriteRegM(WriteRegM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .ValidW(ValidW), .RetireCnt(RetireCnt)
  );

  part_wb #(.CNT_W(4)) dut4 (
    .CLK(CLK), .reset(reset), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .LoadTypeM(LoadTypeM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .WriteRegM(WriteRegM), .RegWriteW(RegWriteW4), .WriteRegW(WriteRegW4),
    .ResultW(ResultW4), .ValidW(ValidW4), .RetireCnt(RetireCnt4)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_m(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wr);
    ValidM = v; RegWriteM = rw; MemtoRegM = m2r; LoadTypeM = lt;
    ALUOutM = alu; ReadDataM = rd; WriteRegM = wr;
  endtask

  task automatic do_reset();
    StallW = 1'b0; FlushW = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%h exp=0", RegWriteW); end
    checks++; if (WriteRegW !== 5'd0) begin errors++; $display("FAIL reset_writereg got=%h exp=0", WriteRegW); end
    checks++; if (ResultW !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", ResultW); end
    checks++; if (ValidW !== 1'b0) begin errors++; $display("FAIL reset_valid got=%h exp=0", ValidW); end
    checks++; if (RetireCnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", RetireCnt); end
  endtask

  task automatic test_alu_write();
    do_reset();
    set_m(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_1234, 32'hDEAD_BEEF, 5'd8);
    tick();
    set_m(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    checks++; if (RegWriteW !== 1'b1) begin errors++; $display("FAIL alu_regwrite got=%h exp=1", RegWriteW); end
    checks++; if (WriteRegW !== 5'd8) begin errors++; $display("FAIL alu_writereg got=%0d exp=8", WriteRegW); end
    checks++; if (ResultW !== 32'h0000_1234) begin errors++; $display("FAIL alu_result got=%h exp=00001234", ResultW); end
    checks++; if (ValidW !== 1'b1) begin errors++; $display("FAIL alu_valid got=%h exp=1", ValidW); end
    checks++; if (RetireCnt !== 32'd1) begin errors++; $display("FAIL alu_cnt got=%0d exp=1", RetireCnt); end
  endtask

  task automatic test_loads();
    logic [2:0]  lt  [12];
    logic [31:0] adr [12];
    logic [31:0] exp [12];
    lt[0]  = 3'd1; adr[0]  = 32'h103; exp[0]  = 32'hFFFF_FF80; // LB lane 3
    lt[1]  = 3'd2; adr[1]  = 32'h103; exp[1]  = 32'h0000_0080; // LBU lane 3
    lt[2]  = 3'd1; adr[2]  = 32'h100; exp[2]  = 32'h0000_0001; // LB lane 0
    lt[3]  = 3'd3; adr[3]  = 32'h100; exp[3]  = 32'h0000_7F01; // LH low
    lt[4]  = 3'd3; adr[4]  = 32'h102; exp[4]  = 32'hFFFF_80FF; // LH high
    lt[5]  = 3'd4; adr[5]  = 32'h102; exp[5]  = 32'h0000_80FF; // LHU high
    lt[6]  = 3'd0; adr[6]  = 32'h103; exp[6]  = 32'h80FF_7F01; // LW, offset ignored
    lt[7]  = 3'd1; adr[7]  = 32'h101; exp[7]  = 32'h0000_007F; // LB lane 1
    lt[8]  = 3'd1; adr[8]  = 32'h102; exp[8]  = 32'hFFFF_FFFF; // LB lane 2
    lt[9]  = 3'd3; adr[9]  = 32'h103; exp[9]  = 32'hFFFF_80FF; // LH misaligned
    lt[10] = 3'd4; adr[10] = 32'h101; exp[10] = 32'h0000_7F01; // LHU misaligned low
    lt[11] = 3'd7; adr[11] = 32'h101; exp[11] = 32'h80FF_7F01; // reserved -> LW
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_m(1'b1, 1'b1, 1'b1, lt[i], adr[i], 32'h80FF_7F01, 5'd4);
      tick();
      checks++;
      if (ResultW !== exp[i]) begin
        errors++; $display("FAIL load_%0d type=%0d got=%h exp=%h", i, lt[i], ResultW, exp[i]);
      end
    end
    checks++; if (RetireCnt !== 32'd12) begin errors++; $display("FAIL load_cnt got=%0d exp=12", RetireCnt); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_m(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_5555, 32'h0, 5'd0);
    tick();
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL zero_regwrite got=%h exp=0", RegWriteW); end
    checks++; if (ResultW !== 32'h0000_5555) begin errors++; $display("FAIL zero_result got=%h exp=00005555", ResultW); end
    checks++; if (RetireCnt !== 32'd1) begin errors++; $display("FAIL zero_cnt got=%0d exp=1", RetireCnt); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    set_m(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_AAAA, 32'h0, 5'd9);
    tick();
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_m(1'b1, 1'b1, 1'b1, 3'd1, 32'h1111_0000 + i, 32'hFFFF_FFFF, 5'd20 + 5'(i));
      tick();
      checks++;
      if (ResultW !== 32'h0000_AAAA || WriteRegW !== 5'd9 || RegWriteW !== 1'b1 || ValidW !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d got=%h/%0d/%h/%h exp=0000aaaa/9/1/1", i, ResultW, WriteRegW, RegWriteW, ValidW);
      end
      checks++;
      if (RetireCnt !== 32'd1) begin errors++; $display("FAIL stall_cnt_%0d got=%0d exp=1", i, RetireCnt); end
    end
    FlushW = 1'b1;
    tick();
    FlushW = 1'b0; StallW = 1'b0;
    checks++; if (ValidW !== 1'b0) begin errors++; $display("FAIL flush_valid got=%h exp=0", ValidW); end
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL flush_regwrite got=%h exp=0", RegWriteW); end
    checks++; if (RetireCnt !== 32'd1) begin errors++; $display("FAIL flush_cnt got=%0d exp=1", RetireCnt); end
    set_m(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0042, 32'h0, 5'd10);
    tick();
    checks++; if (ValidW !== 1'b1 || ResultW !== 32'h42 || RetireCnt !== 32'd2) begin
      errors++; $display("FAIL post_flush got=%h/%h/%0d exp=1/00000042/2", ValidW, ResultW, RetireCnt);
    end
  endtask

  task automatic test_sync_reset();
    do_reset();
    set_m(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0777, 32'h0, 5'd5);
    tick();
    StallW = 1'b1;
    reset = 1'b1;
    #2;
    checks++; if (RegWriteW !== 1'b1 || ResultW !== 32'h777 || RetireCnt !== 32'd1) begin
      errors++; $display("FAIL sync_reset_pre got=%h/%h/%0d exp=1/00000777/1", RegWriteW, ResultW, RetireCnt);
    end
    tick();
    reset = 1'b0; StallW = 1'b0;
    checks++; if (RegWriteW !== 1'b0 || WriteRegW !== 5'd0 || ResultW !== 32'h0 || ValidW !== 1'b0 || RetireCnt !== 32'd0) begin
      errors++; $display("FAIL sync_reset_post got=%h/%0d/%h/%h/%0d exp=all zero", RegWriteW, WriteRegW, ResultW, ValidW, RetireCnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_m(1'b1, 1'b1, 1'b0, 3'd0, 32'd11, 32'h0, 5'd3);
    tick();
    checks++; if (ResultW !== 32'd11 || WriteRegW !== 5'd3 || RegWriteW !== 1'b1) begin
      errors++; $display("FAIL b2b_first got=%0d/%0d/%h exp=11/3/1", ResultW, WriteRegW, RegWriteW);
    end
    set_m(1'b1, 1'b1, 1'b0, 3'd0, 32'd22, 32'h0, 5'd3);
    tick();
    checks++; if (ResultW !== 32'd22 || WriteRegW !== 5'd3 || RegWriteW !== 1'b1 || RetireCnt !== 32'd2) begin
      errors++; $display("FAIL b2b_second got=%0d/%0d/%h/%0d exp=22/3/1/2", ResultW, WriteRegW, RegWriteW, RetireCnt);
    end
    set_m(1'b0, 1'b1, 1'b0, 3'd0, 32'd33, 32'h0, 5'd3);
    tick();
    checks++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || RetireCnt !== 32'd2) begin
      errors++; $display("FAIL invalid_m got=%h/%h/%0d exp=0/0/2", ValidW, RegWriteW, RetireCnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_m(1'b1, 1'b1, 1'b0, 3'd0, 32'(i), 32'h0, 5'd1);
      tick();
    end
    checks++; if (RetireCnt4 !== 4'd1) begin errors++; $display("FAIL wrap_cnt4 got=%0d exp=1", RetireCnt4); end
    checks++; if (RetireCnt !== 32'd17) begin errors++; $display("FAIL wrap_cnt32 got=%0d exp=17", RetireCnt); end
  endtask

  initial begin
    reset = 1'b1; StallW = 1'b0; FlushW = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    test_reset();
    test_alu_write();
    test_loads();
    test_zero_reg();
    test_stall_flush();
    test_sync_reset();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
